// File: rtl/pong_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl_if
// Description : Signal bundle between the Pong match sequencer and its
//               surroundings (frame timing, start button, ball engine,
//               renderer). The sequencer connects through the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_game_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             frame_tick;
   logic             start_btn;
   logic             left_point;
   logic             right_point;
   logic [2:0]       scoreL;
   logic [2:0]       scoreR;
   logic             ball_run;
   logic             game_over;
   logic             match_rst;
   logic [1:0]       winner;
   logic [2:0]       state;
   logic [CNT_W-1:0] countdown;

   // Sequencer side: consumes timing/button/point inputs, drives match control
   modport master (
      input  frame_tick,
      input  start_btn,
      input  left_point,
      input  right_point,
      input  scoreL,
      input  scoreR,
      output ball_run,
      output game_over,
      output match_rst,
      output winner,
      output state,
      output countdown
   );

   // Environment side: ball engine, renderer, button and video timing
   modport slave (
      output frame_tick,
      output start_btn,
      output left_point,
      output right_point,
      output scoreL,
      output scoreR,
      input  ball_run,
      input  game_over,
      input  match_rst,
      input  winner,
      input  state,
      input  countdown
   );
endinterface
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong match sequencer. Owns IDLE / SERVE / PLAY / PAUSE / OVER,
//               gates ball motion, drives the ball engine freeze flag and
//               issues a one-clock match-restart pulse.
// Options     : AUTO_RESTART_EN - when defined, OVER counts RESTART_FRAMES
//               frame ticks and then falls back to IDLE on its own.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
   parameter int WIN_SCORE      = 7,
   parameter int SERVE_FRAMES   = 60,
   parameter int PAUSE_FRAMES   = 90,
   parameter int CNT_W          = 8,
   parameter int RESTART_FRAMES = 240
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   pong_game_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] c_serve_load = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0] c_pause_load = CNT_W'(PAUSE_FRAMES);
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
   localparam logic [2:0]       c_win_score  = 3'(WIN_SCORE);
`ifdef AUTO_RESTART_EN
   localparam logic [CNT_W-1:0] c_over_load  = CNT_W'(RESTART_FRAMES);
`else
   localparam logic [CNT_W-1:0] c_over_load  = '0;
`endif
   localparam longint c_cnt_max = (64'd1 << CNT_W) - 64'd1;

   // Catch parameter sets the counter or the 3-bit score cannot represent
   if ((SERVE_FRAMES < 0) || (PAUSE_FRAMES < 0) || (RESTART_FRAMES < 0) ||
       (longint'(SERVE_FRAMES)   > c_cnt_max) ||
       (longint'(PAUSE_FRAMES)   > c_cnt_max) ||
       (longint'(RESTART_FRAMES) > c_cnt_max)) begin : g_cnt_w_check
      $error("pong_game_ctrl: CNT_W too small for the frame counts");
   end
   if ((WIN_SCORE < 1) || (WIN_SCORE > 7)) begin : g_win_score_check
      $error("pong_game_ctrl: WIN_SCORE must be in 1..7");
   end

   // ------------------------------------------------------------------------
   // Start button: two-flop synchroniser, then a registered rising-edge
   // detector. Pin-to-pulse latency is three clocks; a held button gives a
   // single pulse because the pulse needs a fresh 0->1 on the synced level.
   // ------------------------------------------------------------------------
   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic r_start_pulse;

   // Synchronise the raw button and register its rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1       <= 1'b0;
         r_sync2       <= 1'b0;
         r_sync3       <= 1'b0;
         r_start_pulse <= 1'b0;
      end else begin
         r_sync1       <= bus.start_btn;
         r_sync2       <= r_sync1;
         r_sync3       <= r_sync2;
         r_start_pulse <= r_sync2 & ~r_sync3;
      end
   end

   // ------------------------------------------------------------------------
   // Match state machine
   // ------------------------------------------------------------------------
   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [1:0]       r_winner;
   logic             r_match_rst;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_count_nxt;
   logic [1:0]       w_winner_nxt;
   logic             w_match_rst_nxt;

   // State, countdown, winner and restart-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_winner    <= 2'b00;
         r_match_rst <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_winner    <= w_winner_nxt;
         r_match_rst <= w_match_rst_nxt;
      end
   end

   // Next-state logic; a tick arriving with an event is dropped because the
   // event branch always wins and loads a fresh count for the new state
   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_winner_nxt    = r_winner;
      w_match_rst_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_count_nxt  = '0;
            w_winner_nxt = 2'b00;
            if (r_start_pulse) begin
               w_match_rst_nxt = 1'b1;
               w_count_nxt     = c_serve_load;
               w_state_nxt     = ST_SERVE;
            end
         end

         ST_SERVE, ST_PAUSE: begin
            // A zero load passes straight through in one clock
            if (r_count == '0) begin
               w_state_nxt = ST_PLAY;
            end else if (bus.frame_tick) begin
               w_count_nxt = r_count - c_cnt_one;
               if (r_count == c_cnt_one) begin
                  w_state_nxt = ST_PLAY;
               end
            end
         end

         ST_PLAY: begin
            w_count_nxt = '0;
            // Left has priority if the engine ever reports both at once
            if (bus.left_point) begin
               if (bus.scoreL >= c_win_score) begin
                  w_winner_nxt = 2'b01;
                  w_count_nxt  = c_over_load;
                  w_state_nxt  = ST_OVER;
               end else begin
                  w_count_nxt  = c_pause_load;
                  w_state_nxt  = ST_PAUSE;
               end
            end else if (bus.right_point) begin
               if (bus.scoreR >= c_win_score) begin
                  w_winner_nxt = 2'b10;
                  w_count_nxt  = c_over_load;
                  w_state_nxt  = ST_OVER;
               end else begin
                  w_count_nxt  = c_pause_load;
                  w_state_nxt  = ST_PAUSE;
               end
            end
         end

         ST_OVER: begin
            if (r_start_pulse) begin
               w_winner_nxt    = 2'b00;
               w_match_rst_nxt = 1'b1;
               w_count_nxt     = c_serve_load;
               w_state_nxt     = ST_SERVE;
`ifdef AUTO_RESTART_EN
            end else if (r_count == '0) begin
               w_winner_nxt = 2'b00;
               w_state_nxt  = ST_IDLE;
            end else if (bus.frame_tick) begin
               w_count_nxt = r_count - c_cnt_one;
               if (r_count == c_cnt_one) begin
                  w_winner_nxt = 2'b00;
                  w_state_nxt  = ST_IDLE;
               end
            end
`else
            end else begin
               w_count_nxt = '0;
            end
`endif
         end

         default: begin
            w_state_nxt  = ST_IDLE;
            w_count_nxt  = '0;
            w_winner_nxt = 2'b00;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs: run/freeze decode straight from the state register
   // ------------------------------------------------------------------------
   assign bus.ball_run  = (r_state == ST_PLAY);
   assign bus.game_over = (r_state == ST_OVER);
   assign bus.match_rst = r_match_rst;
   assign bus.winner    = r_winner;
   assign bus.state     = r_state;
   assign bus.countdown = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Directed self-checking bench for pong_game_ctrl with
//               hand-computed expectations at each step.
// Options     : AUTO_RESTART_EN - enables the auto-restart checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

   localparam int c_cnt_w = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   pong_game_ctrl_if #(.CNT_W(c_cnt_w)) bus ();

   pong_game_ctrl #(
      .WIN_SCORE      (7),
      .SERVE_FRAMES   (60),
      .PAUSE_FRAMES   (90),
      .CNT_W          (c_cnt_w),
      .RESTART_FRAMES (4)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n clocks and settle 1 time unit past the last rising edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Press start and follow the synchroniser: pulse appears four clocks later
   task automatic press_start(input string tag);
      bus.start_btn = 1'b1;
      step(3);
      chk({tag, "_no_rst_early"}, {31'd0, bus.match_rst}, 32'd0);
      step(1);
      chk({tag, "_match_rst"}, {31'd0, bus.match_rst}, 32'd1);
      chk({tag, "_state_serve"}, {29'd0, bus.state}, 32'd1);
      chk({tag, "_cnt_60"}, {24'd0, bus.countdown}, 32'd60);
      chk({tag, "_winner_clr"}, {30'd0, bus.winner}, 32'd0);
      step(1);
      bus.start_btn = 1'b0;
      chk({tag, "_rst_one_clk"}, {31'd0, bus.match_rst}, 32'd0);
   endtask

   // Run the 60-tick serve countdown into PLAY
   task automatic serve_to_play(input string tag);
      bus.frame_tick = 1'b1;
      step(59);
      chk({tag, "_cnt_1"}, {24'd0, bus.countdown}, 32'd1);
      chk({tag, "_still_serve"}, {29'd0, bus.state}, 32'd1);
      step(1);
      bus.frame_tick = 1'b0;
      chk({tag, "_play"}, {29'd0, bus.state}, 32'd2);
      chk({tag, "_ball_run"}, {31'd0, bus.ball_run}, 32'd1);
      chk({tag, "_cnt_0"}, {24'd0, bus.countdown}, 32'd0);
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      bus.frame_tick  = 1'b0;
      bus.start_btn   = 1'b0;
      bus.left_point  = 1'b0;
      bus.right_point = 1'b0;
      bus.scoreL      = 3'd0;
      bus.scoreR      = 3'd0;

      // Reset state
      step(3);
      chk("rst_state", {29'd0, bus.state}, 32'd0);
      chk("rst_ball_run", {31'd0, bus.ball_run}, 32'd0);
      chk("rst_game_over", {31'd0, bus.game_over}, 32'd0);
      chk("rst_match_rst", {31'd0, bus.match_rst}, 32'd0);
      chk("rst_winner", {30'd0, bus.winner}, 32'd0);
      chk("rst_countdown", {24'd0, bus.countdown}, 32'd0);
      rst_n = 1'b1;
      step(2);
      chk("idle_no_tick_count", {24'd0, bus.countdown}, 32'd0);

      // Start held for 5 clocks: one pulse four clocks after the press
      press_start("start1");
      step(6);
      chk("held_no_second_rst", {31'd0, bus.match_rst}, 32'd0);
      chk("serve_ball_hold", {31'd0, bus.ball_run}, 32'd0);

      serve_to_play("serve1");

      // Non-winning left point with a coincident tick: tick not counted
      bus.scoreL      = 3'd2;
      bus.left_point  = 1'b1;
      bus.frame_tick  = 1'b1;
      step(1);
      bus.left_point  = 1'b0;
      bus.frame_tick  = 1'b0;
      chk("lpt_pause", {29'd0, bus.state}, 32'd3);
      chk("lpt_ball_hold", {31'd0, bus.ball_run}, 32'd0);
      chk("lpt_cnt_90", {24'd0, bus.countdown}, 32'd90);

      // Points during PAUSE are ignored
      bus.scoreL     = 3'd7;
      bus.left_point = 1'b1;
      step(1);
      bus.left_point = 1'b0;
      chk("pause_ignore_state", {29'd0, bus.state}, 32'd3);
      chk("pause_ignore_winner", {30'd0, bus.winner}, 32'd0);
      chk("pause_ignore_cnt", {24'd0, bus.countdown}, 32'd90);

      bus.frame_tick = 1'b1;
      step(89);
      chk("pause_cnt_1", {24'd0, bus.countdown}, 32'd1);
      step(1);
      bus.frame_tick = 1'b0;
      chk("pause_to_play", {29'd0, bus.state}, 32'd2);
      chk("pause_to_play_run", {31'd0, bus.ball_run}, 32'd1);

      // Winning right point
      bus.scoreR      = 3'd7;
      bus.right_point = 1'b1;
      step(1);
      bus.right_point = 1'b0;
      chk("rwin_state", {29'd0, bus.state}, 32'd4);
      chk("rwin_game_over", {31'd0, bus.game_over}, 32'd1);
      chk("rwin_winner", {30'd0, bus.winner}, 32'd2);
      chk("rwin_ball_hold", {31'd0, bus.ball_run}, 32'd0);
`ifdef AUTO_RESTART_EN
      chk("rwin_cnt", {24'd0, bus.countdown}, 32'd4);
`else
      chk("rwin_cnt", {24'd0, bus.countdown}, 32'd0);
`endif

      // Further points in OVER change nothing
      bus.left_point  = 1'b1;
      bus.right_point = 1'b1;
      step(1);
      bus.left_point  = 1'b0;
      bus.right_point = 1'b0;
      chk("over_ignore_state", {29'd0, bus.state}, 32'd4);
      chk("over_ignore_winner", {30'd0, bus.winner}, 32'd2);

      // Restart from OVER by button
      press_start("start2");
      serve_to_play("serve2");

      // Simultaneous points, both winning: left has priority
      bus.scoreL      = 3'd7;
      bus.scoreR      = 3'd7;
      bus.left_point  = 1'b1;
      bus.right_point = 1'b1;
      step(1);
      bus.left_point  = 1'b0;
      bus.right_point = 1'b0;
      chk("both_state", {29'd0, bus.state}, 32'd4);
      chk("both_winner", {30'd0, bus.winner}, 32'd1);

`ifdef AUTO_RESTART_EN
      // Auto-restart: four ticks back to IDLE, no restart pulse
      bus.frame_tick = 1'b1;
      step(3);
      chk("auto_cnt_1", {24'd0, bus.countdown}, 32'd1);
      chk("auto_still_over", {29'd0, bus.state}, 32'd4);
      step(1);
      bus.frame_tick = 1'b0;
      chk("auto_idle", {29'd0, bus.state}, 32'd0);
      chk("auto_winner_clr", {30'd0, bus.winner}, 32'd0);
      chk("auto_no_match_rst", {31'd0, bus.match_rst}, 32'd0);
      chk("auto_no_game_over", {31'd0, bus.game_over}, 32'd0);
`else
      // Without auto-restart, OVER holds through frame ticks
      bus.frame_tick = 1'b1;
      step(10);
      bus.frame_tick = 1'b0;
      chk("hold_over_state", {29'd0, bus.state}, 32'd4);
      chk("hold_over_winner", {30'd0, bus.winner}, 32'd1);
      chk("hold_over_cnt", {24'd0, bus.countdown}, 32'd0);
`endif

      // Mid-match reset: asynchronous return to IDLE before the next edge
      press_start("start3");
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", {29'd0, bus.state}, 32'd0);
      chk("async_rst_cnt", {24'd0, bus.countdown}, 32'd0);
      chk("async_rst_winner", {30'd0, bus.winner}, 32'd0);
      step(1);
      rst_n = 1'b1;
      step(2);
      chk("post_rst_idle", {29'd0, bus.state}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level match sequencer for the Pong datapath. It owns the game state: idle/attract, serve countdown, live play, post-point pause and game over.
- It gates ball motion, drives the `game_over` freeze input of the ball engine, and issues a match-restart pulse that clears scores and recentres the ball.
- It sits between the player start button, the VGA frame tick and the ball engine's point/score outputs.

Parameters:
- WIN_SCORE, 7, score (3-bit) that ends the match; legal range 1..7.
- SERVE_FRAMES, 60, frame ticks of countdown before the ball is released.
- PAUSE_FRAMES, 90, frame ticks the ball is held after a point.
- CNT_W, 8, width of the frame countdown counter; must hold max(SERVE_FRAMES, PAUSE_FRAMES, RESTART_FRAMES).
- RESTART_FRAMES, 240, frame ticks in GAME_OVER before auto-restart (used only with AUTO_RESTART_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-clk pulse per video frame
- start_btn  in  1  raw, asynchronous start button, active-high
- left_point  in  1  one-clk pulse from ball engine: left player scored
- right_point  in  1  one-clk pulse from ball engine: right player scored
- scoreL  in  3  left score, updated on the same edge as left_point
- scoreR  in  3  right score, updated on the same edge as right_point
- ball_run  out  1  1 = ball engine may advance; 0 = hold the ball
- game_over  out  1  freeze/win-screen flag to ball engine and renderer
- match_rst  out  1  one-clk active-high pulse; top ORs it into the ball engine reset
- winner  out  2  00 none, 01 left, 10 right
- state  out  3  encoded FSM state for the renderer (IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4)
- countdown  out  CNT_W  remaining frames in SERVE/PAUSE/OVER, 0 otherwise

Behaviour:
- Reset values: state=IDLE, ball_run=0, game_over=0, match_rst=0, winner=00, countdown=0, synchroniser flops=0.
- start_btn path:
  - Two-flop synchroniser, then rising-edge detect to give start_pulse.
  - Latency from pin to start_pulse is 3 clk.
  - A held button generates exactly one pulse.
- IDLE:
  - ball_run=0, game_over=0.
  - On start_pulse: assert match_rst for 1 clk, load countdown=SERVE_FRAMES, go to SERVE.
- SERVE:
  - ball_run=0.
  - Countdown decrements on each frame_tick.
  - On the frame_tick that takes the count from 1 to 0, go to PLAY on the next edge.
  - start_pulse is ignored.
- PLAY:
  - ball_run=1 (combinational from state).
  - Scores are already updated in the same cycle as a point pulse, so they are compared in that cycle.
  - On left_point: if scoreL >= WIN_SCORE, winner=01 and go to OVER. Otherwise load PAUSE_FRAMES and go to PAUSE.
  - On right_point: same rule, using scoreR and winner=10.
  - left_point and right_point both high: the left pulse has priority. This is illegal from the ball engine, but the response is defined.
- PAUSE:
  - ball_run=0.
  - Countdown as in SERVE; on reaching 0, go to PLAY.
  - Point pulses are ignored.
- OVER:
  - game_over=1, ball_run=0, winner held.
  - On start_pulse: clear winner, pulse match_rst, load SERVE_FRAMES, go to SERVE.
- frame_tick and an event (a point pulse or start_pulse) in the same cycle: the state transition is taken and the tick is not counted in the new state.
- Countdown is loaded on entry to a state and does not wrap. SERVE_FRAMES=0 or PAUSE_FRAMES=0 gives a 1-clk transit through the state.
- match_rst is registered; it is high exactly in the cycle after the transition edge.
- Reset asserted mid-match: immediate return to IDLE. The ball engine is reset by the same rst_n.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro AUTO_RESTART_EN.
- Defined:
  - On entering OVER, load RESTART_FRAMES into the countdown, decremented by frame_tick.
  - At 0: clear winner, go to IDLE (no match_rst pulse).
  - start_pulse in OVER still restarts immediately, as in the base behaviour.
- Undefined: OVER is held until start_pulse; countdown reads 0 in OVER.

Test Plan:
- Reset, then start_btn high for 5 clk. Expect: exactly one match_rst pulse 4 clk after the button rises, state=SERVE, countdown=60.
- SERVE_FRAMES=3, 3 frame_ticks. Expect: state=PLAY with ball_run=1 one clk after the third tick.
- In PLAY, left_point with scoreL=2. Expect: state=PAUSE, ball_run=0, countdown=90; after 90 ticks, PLAY.
- In PLAY, right_point with scoreR=7. Expect: state=OVER, game_over=1, winner=10; subsequent point pulses cause no change.
- left_point and right_point together with scoreL=7, scoreR=7. Expect: winner=01.
- OVER, then start_btn. Expect: winner=00, match_rst pulse, state=SERVE. With AUTO_RESTART_EN and RESTART_FRAMES=4 and no button: IDLE after 4 ticks.
